data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_resp_pkg.sv | 25 ++
 rtl/word_ram.sv | 35 +++
 rtl/data_mem_responder.sv | 92 +++++++++
 tb/tb_data_mem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types for the data memory responder: FSM states, widths,
// request capture record and the address error encoding.
package mem_resp_pkg;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  typedef enum logic {ERR_OK = 1'b0, ERR_BAD = 1'b1} err_t;

  typedef struct packed {
    logic                 write;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wdata;
    logic [NUM_LANES-1:0] wstrb;
  } req_t;

  // Misaligned or beyond the last word -> error.
  function automatic err_t addr_check(input logic [ADDR_W-1:0] addr,
                                      input int unsigned depth);
    if (addr[1:0] != 2'b00 || 32'(addr[ADDR_W-1:2]) >= depth) return ERR_BAD;
    return ERR_OK;
  endfunction
endpackage

// File: rtl/word_ram.sv
// DEPTH x 32 word store with per-byte write enables, synchronous write,
// combinational read; word i powers up holding the value i.
module word_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int IDX_W = 7
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [IDX_W-1:0]          addr,
  input  logic [NUM_LANES-1:0]      wstrb,
  input  logic [NUM_LANES-1:0][7:0] wdata,
  output logic [NUM_LANES-1:0][7:0] rdata
);
  typedef logic [NUM_LANES-1:0][7:0] mem_t [DEPTH];

  function automatic mem_t init_words();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
    return m;
  endfunction

  // Power-up image only; there is deliberately no reset path into storage.
  mem_t mem = init_words();

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < NUM_LANES; k++)
        if (wstrb[k]) mem[addr][k] <= wdata[k];
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder: IDLE -> WAIT (LATENCY cycles) -> RESP,
// committing stores and sampling load data on the edge that enters RESP.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [NUM_LANES-1:0] req_wstrb,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic                 resp_err
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  req_t        cur;
  req_t        req_in;
  req_t        act;
  err_t        act_err;
  logic        accept;
  logic        enter_resp;
  logic        ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
  assign accept = (state == ST_IDLE) && req_ready && req_valid;
  assign enter_resp = (accept && LATENCY == 0) || (state == ST_WAIT && cnt == 4'd0);

  // With zero latency the request is served straight from the inputs.
  assign act     = (state == ST_IDLE) ? req_in : cur;
  assign act_err = addr_check(act.addr, DEPTH);
  assign ram_we  = enter_resp && act.write && (act_err == ERR_OK);

  word_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (act.addr[IDX_W+1:2]),
    .wstrb (act.wstrb),
    .wdata (act.wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) begin
          cur       <= req_in;
          req_ready <= 1'b0;
          if (LATENCY == 0) state <= ST_RESP;
          else begin
            state <= ST_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        ST_WAIT: if (cnt == 4'd0) state <= ST_RESP;
                 else cnt <= cnt - 4'd1;
        ST_RESP: if (resp_ready) begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
      // Load data is the pre-store word value, read in the same cycle as the commit.
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= (act_err == ERR_BAD);
        resp_rdata <= (act.write || act_err == ERR_BAD) ? '0 : ram_rdata;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench: driver pushes model-predicted responses,
// a negedge monitor pops and compares whenever resp_valid appears.
module tb_data_mem_responder;
  localparam int DEPTH = 128;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;

  logic        r0_req_valid = 1'b0, r0_req_ready, r0_req_write = 1'b0;
  logic [31:0] r0_req_addr = '0, r0_req_wdata = '0;
  logic [3:0]  r0_req_wstrb = '0;
  logic        r0_resp_valid, r0_resp_ready = 1'b0, r0_resp_err;
  logic [31:0] r0_resp_rdata;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err));

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(r0_req_valid), .req_ready(r0_req_ready),
    .req_write(r0_req_write), .req_addr(r0_req_addr), .req_wdata(r0_req_wdata),
    .req_wstrb(r0_req_wstrb), .resp_valid(r0_resp_valid), .resp_ready(r0_resp_ready),
    .resp_rdata(r0_resp_rdata), .resp_err(r0_resp_err));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [DEPTH];
  int          total = 0, bad = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic        holding = 1'b0;
  logic [31:0] held_rdata;
  logic        held_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference: word store as a plain array, errors from the address rule.
  function automatic exp_t predict(input logic w, input logic [31:0] a,
                                   input logic [31:0] d, input logic [3:0] s, input int acc);
    exp_t e;
    int   idx;
    e.acc = acc;
    idx   = int'(a / 4);
    if (a % 4 != 0 || a / 4 >= DEPTH) begin
      e.rdata = 0; e.err = 1;
    end else if (w) begin
      for (int k = 0; k < 4; k++)
        if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
      e.rdata = 0; e.err = 0;
    end else begin
      e.rdata = model[idx]; e.err = 0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (resp_valid) begin
        chk("req_ready_low_in_resp", {31'd0, req_ready}, 32'd0);
        if (!holding) begin
          if (sbq.size() == 0) begin
            timeout("unexpected_response");
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("rdata", resp_rdata, e.rdata);
            chk("err", {31'd0, resp_err}, {31'd0, e.err});
            chk("latency", 32'(cyc - e.acc), 32'(LAT));
          end
          holding    = 1'b1;
          held_rdata = resp_rdata;
          held_err   = resp_err;
        end else begin
          chk("rdata_stable", resp_rdata, held_rdata);
          chk("err_stable", {31'd0, resp_err}, {31'd0, held_err});
        end
      end else begin
        holding = 1'b0;
        chk("idle_rdata_zero", resp_rdata, 32'd0);
        chk("idle_err_zero", {31'd0, resp_err}, 32'd0);
      end
    end
  end

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int bp);
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    if (!req_ready) begin timeout("req_ready_wait"); return; end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    sbq.push_back(predict(w, a, d, s, cyc + 1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    t = 0;
    @(negedge clk);
    while (!resp_valid && t < 40) begin @(negedge clk); t++; end
    if (!resp_valid) begin timeout("resp_valid_wait"); return; end
    repeat (bp) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("req_ready_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 32'(i);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);
    chk("reset_err", {31'd0, resp_err}, 32'd0);
    mon_en = 1'b1;

    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h20, 32'hDEADBEEF, 4'b0101, 0);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0);
    do_req(1'b0, 32'h22, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, 0);
    do_req(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h30, 32'h12345678, 4'b0000, 1);
    do_req(1'b0, 32'h30, 32'h0, 4'h0, 5);

    // Store abandoned by reset while waiting.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h04;
    req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("midwait_reset_ready", {31'd0, req_ready}, 32'd1);
    chk("midwait_reset_valid", {31'd0, resp_valid}, 32'd0);
    repeat (4) @(negedge clk);
    do_req(1'b0, 32'h04, 32'h0, 4'h0, 0);

    for (int n = 0; n < 200; n++) begin
      int          kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 9));
      if (kind < 7)       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (kind == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (kind == 8) a = (32'(DEPTH) + 32'($urandom_range(0, 1000))) * 4;
      else                a = $urandom | 32'h8000_0000;
      do_req(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end

    // Zero-latency build: response visible right after the accept edge.
    @(negedge clk);
    chk("l0_req_ready", {31'd0, r0_req_ready}, 32'd1);
    r0_req_valid = 1'b1; r0_req_write = 1'b0; r0_req_addr = 32'h0C;
    @(posedge clk); #1 r0_req_valid = 1'b0; r0_req_addr = 32'h40;
    @(negedge clk);
    chk("l0_resp_valid", {31'd0, r0_resp_valid}, 32'd1);
    chk("l0_rdata", r0_resp_rdata, 32'd3);
    chk("l0_err", {31'd0, r0_resp_err}, 32'd0);
    chk("l0_req_ready_busy", {31'd0, r0_req_ready}, 32'd0);
    r0_resp_ready = 1'b1;
    @(posedge clk); #1 r0_resp_ready = 1'b0;
    @(negedge clk);
    chk("l0_resp_valid_drop", {31'd0, r0_resp_valid}, 32'd0);
    chk("l0_req_ready_back", {31'd0, r0_req_ready}, 32'd1);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
